pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the five-stage CPU, replacing the fixed-field, hold-on-not-ready stage registers.
- Carries an opaque DATA_W-bit payload bundle (pc, rd, alu_result, csr fields, exception bits, ...) under a valid/ready handshake.
- Supports flush on exception/ertn and an optional skid entry so that in_ready is registered (SKID=1).
- Placed between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 256, payload width in bits (>=1).
- SKID, 1, 0 = single entry with combinational in_ready; 1 = main + skid entry with registered in_ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill all held entries (exception/ertn taken in WB).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  buffer can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output entry.
- out_data  out  DATA_W  output payload (main entry).
- occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - main and skid valid = 0; main and skid data = 0; stall_cnt = 0.
  - Hence out_valid=0, out_data=0, occupancy=0.
  - in_ready = 1 while in reset when SKID=1; follows the SKID=0 equation when SKID=0.
  - Deassertion takes effect at the next clk edge; no synchronous rst.
- Handshake terms: accept = in_valid & in_ready; drain = out_valid & out_ready.
  - No combinational path from in_valid/in_data to out_valid/out_data; latency is exactly 1 cycle when empty.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational from out_ready).
  - On accept: main <= in_data, main_valid <= 1.
  - Else on drain: main_valid <= 0.
  - Simultaneous accept and drain: new beat replaces the old one, no bubble.
- SKID=1:
  - in_ready = !skid_valid (register output only).
  - States by (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE:
    - accept & drain -> ONE, main <= in_data.
    - accept & !drain -> FULL, skid <= in_data.
    - drain & !accept -> EMPTY.
    - neither -> hold.
  - FULL (accept impossible, in_ready=0): drain -> ONE, main <= skid, skid_valid <= 0. Otherwise hold.
  - Ordering is strictly FIFO; no beat is dropped or duplicated unless flushed.
- Flush:
  - Sampled at the clock edge; highest priority after reset.
  - All valid bits <= 0; a beat offered in the same cycle is dropped even if in_ready=1.
  - A drain in the same cycle still counts as completed downstream.
  - Data registers are not cleared on flush (only valids).
  - stall_cnt is not cleared by flush.
  - in_ready=1 from the cycle after a flush when SKID=1.
- Data registers load only on the accept/transfer events above; otherwise they hold their value.
- stall_cnt: increments by 1 each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1; never wraps.
- occupancy = main_valid + skid_valid, registered-state derived; main_valid=0 with skid_valid=1 is illegal and unreachable.
- Throughput: with SKID=1, out_ready held high and in_valid held high, one beat per cycle is sustained indefinitely.

Test Plan:
- Reset, then stream (SKID=1, DATA_W=32): in_valid=1 with data 0x10,0x11,0x12,... and out_ready=1.
  -> out_valid rises 1 cycle after the first accept; out_data=0x10,0x11,0x12 on consecutive cycles; in_ready stays 1; occupancy=1.
- Backpressure (SKID=1): stream 0xA0,0xA1,0xA2 and drop out_ready for 3 cycles.
  -> occupancy reaches 2 and in_ready=0; 0xA2 is held upstream; stall_cnt=3.
  -> After out_ready returns, output is 0xA0,0xA1,0xA2 in order with no loss.
- Flush with a simultaneous offer: buffer FULL (0xB0,0xB1) with in_valid=1 carrying 0xB2; assert flush for 1 cycle.
  -> Next cycle out_valid=0, occupancy=0, in_ready=1; 0xB2 never appears at the output.
- SKID=0 replace: main holds 0xC0, out_ready=1, in_valid=1 carrying 0xC1.
  -> in_ready=1 in the same cycle; next cycle out_data=0xC1 with no bubble.
  -> With out_ready=0: in_ready=0 and 0xC0 is held.
- Async reset mid-operation: FULL with stall_cnt=5; pull rst_n low between clock edges.
  -> out_valid=0, out_data=0, occupancy=0, stall_cnt=0 immediately, without waiting for a clk edge.
- Saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles.
  -> stall_cnt stops at 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with flush and an optional skid entry; 1-cycle latency when empty.
// Backpressure: SKID=1 keeps in_ready registered (drops only when both entries are full); SKID=0 passes out_ready through.
module pipe_stage_buf #(
  parameter int DATA_W = 256,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              drain;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);

  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !skid_valid;
    end else begin : g_pass_ready
      assign in_ready = !main_valid || out_ready;
    end
  endgenerate

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush kills every held entry and drops any beat offered in the same cycle.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else if (SKID == 0) begin
      if (accept) begin
        state_nxt    = ST_ONE;
        load_main_in = 1'b1;
      end else if (drain) begin
        state_nxt = ST_EMPTY;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_nxt      = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
    end else if (load_main_in) begin
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
    end
  end

  // Saturating: holds at all-ones instead of wrapping; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: SKID=1 stream/backpressure/flush/async reset, SKID=0 replace/hold, 4-bit stall saturation.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SKID=1, DATA_W=32
  logic        fl1, v1, r1, ov1, or1;
  logic [31:0] d1, od1;
  logic [1:0]  occ1;
  logic [15:0] sc1;
  // SKID=0, DATA_W=32
  logic        fl0, v0, r0, ov0, or0;
  logic [31:0] d0, od0;
  logic [1:0]  occ0;
  logic [15:0] sc0;
  // SKID=1, DATA_W=8, CNT_W=4
  logic        fls, vs, rs, ovs, ors;
  logic [7:0]  ds, ods;
  logic [1:0]  occs;
  logic [3:0]  scs;

  pipe_stage_buf #(.DATA_W(32), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1), .stall_cnt(sc1));

  pipe_stage_buf #(.DATA_W(32), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0), .stall_cnt(sc0));

  pipe_stage_buf #(.DATA_W(8), .SKID(1), .CNT_W(4)) us (
    .clk(clk), .rst_n(rst_n), .flush(fls), .in_valid(vs), .in_ready(rs), .in_data(ds),
    .out_valid(ovs), .out_ready(ors), .out_data(ods), .occupancy(occs), .stall_cnt(scs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    fl1 = 0; v1 = 0; d1 = '0; or1 = 0;
    fl0 = 0; v0 = 0; d0 = '0; or0 = 0;
    fls = 0; vs = 0; ds = '0; ors = 0;
    #1;
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_od1", od1, 32'h0);
    chk("rst_occ1", 32'(occ1), 32'd0);
    chk("rst_rdy1", 32'(r1), 32'd1);
    chk("rst_sc1", 32'(sc1), 32'd0);
    chk("rst_rdy0", 32'(r0), 32'd1);
    #11 rst_n = 1'b1;
    tick();

    // Streaming, one beat per cycle
    v1 = 1; d1 = 32'h10; or1 = 1;
    tick();
    chk("str_ov", 32'(ov1), 32'd1);
    chk("str_d10", od1, 32'h10);
    chk("str_rdy", 32'(r1), 32'd1);
    chk("str_occ", 32'(occ1), 32'd1);
    d1 = 32'h11;
    tick();
    chk("str_d11", od1, 32'h11);
    d1 = 32'h12;
    tick();
    chk("str_d12", od1, 32'h12);
    chk("str_rdy2", 32'(r1), 32'd1);
    chk("str_sc", 32'(sc1), 32'd0);
    v1 = 0;
    tick();
    chk("str_empty", 32'(ov1), 32'd0);
    chk("str_occ0", 32'(occ1), 32'd0);

    // Backpressure into the skid entry
    v1 = 1; d1 = 32'hA0; or1 = 0;
    tick();
    chk("bp_a0", od1, 32'hA0);
    chk("bp_occ1", 32'(occ1), 32'd1);
    d1 = 32'hA1;
    tick();
    chk("bp_occ2", 32'(occ1), 32'd2);
    chk("bp_rdy0", 32'(r1), 32'd0);
    chk("bp_sc1", 32'(sc1), 32'd1);
    d1 = 32'hA2;
    tick();
    chk("bp_hold", od1, 32'hA0);
    chk("bp_sc2", 32'(sc1), 32'd2);
    tick();
    chk("bp_sc3", 32'(sc1), 32'd3);
    chk("bp_occ2b", 32'(occ1), 32'd2);
    or1 = 1;
    tick();
    chk("bp_a1", od1, 32'hA1);
    chk("bp_occ_one", 32'(occ1), 32'd1);
    chk("bp_rdy1", 32'(r1), 32'd1);
    tick();
    chk("bp_a2", od1, 32'hA2);
    chk("bp_sc_keep", 32'(sc1), 32'd3);
    v1 = 0;
    tick();
    chk("bp_drained", 32'(ov1), 32'd0);

    // Flush while FULL with a simultaneous offer
    v1 = 1; d1 = 32'hB0; or1 = 0;
    tick();
    d1 = 32'hB1;
    tick();
    chk("fl_full", 32'(occ1), 32'd2);
    chk("fl_sc4", 32'(sc1), 32'd4);
    d1 = 32'hB2; fl1 = 1; or1 = 1;
    tick();
    chk("fl_ov", 32'(ov1), 32'd0);
    chk("fl_occ", 32'(occ1), 32'd0);
    chk("fl_rdy", 32'(r1), 32'd1);
    chk("fl_sc_kept", 32'(sc1), 32'd4);
    chk("fl_data_kept", od1, 32'hB0);
    fl1 = 0; v1 = 0;
    tick();
    chk("fl_no_b2", 32'(ov1), 32'd0);

    // Async reset mid-operation
    v1 = 1; d1 = 32'hE0; or1 = 0;
    tick();
    d1 = 32'hE1;
    tick();
    chk("ar_full", 32'(occ1), 32'd2);
    chk("ar_sc5", 32'(sc1), 32'd5);
    v1 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(ov1), 32'd0);
    chk("ar_od", od1, 32'h0);
    chk("ar_occ", 32'(occ1), 32'd0);
    chk("ar_sc", 32'(sc1), 32'd0);
    chk("ar_rdy", 32'(r1), 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // SKID=0: hold then replace without bubble
    v0 = 1; d0 = 32'hC0; or0 = 0;
    tick();
    chk("s0_c0", od0, 32'hC0);
    chk("s0_ov", 32'(ov0), 32'd1);
    chk("s0_occ", 32'(occ0), 32'd1);
    d0 = 32'hC1;
    #1;
    chk("s0_rdy_lo", 32'(r0), 32'd0);
    tick();
    chk("s0_held", od0, 32'hC0);
    chk("s0_sc", 32'(sc0), 32'd1);
    or0 = 1;
    #1;
    chk("s0_rdy_hi", 32'(r0), 32'd1);
    tick();
    chk("s0_c1", od0, 32'hC1);
    chk("s0_nobubble", 32'(ov0), 32'd1);
    v0 = 0;
    tick();
    chk("s0_empty", 32'(occ0), 32'd0);

    // Stall counter saturation at 15
    vs = 1; ds = 8'h5A; ors = 0;
    tick();
    vs = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_14", 32'(scs), 32'd14);
      if (i == 15) chk("sat_15", 32'(scs), 32'd15);
    end
    chk("sat_hold", 32'(scs), 32'd15);
    chk("sat_ov", 32'(ovs), 32'd1);
    chk("sat_od", 32'(ods), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
